// File: rtl/row_col_sequencer_if.sv
// Load/issue bus of the row/column sequencer.
// The master writes A/B and starts runs; the slave presents row/column pairs.
interface row_col_sequencer_if #(
  parameter int Width = 8
);
  logic               LoadValid;
  logic               LoadSel;
  logic [3:0]         LoadAddr;
  logic [Width-1:0]   LoadReal;
  logic [Width-1:0]   LoadImag;
  logic               Start;
  logic               Hold;
  logic               Enable;
  logic [1:0]         RowIdx;
  logic [1:0]         ColIdx;
  logic [4*Width-1:0] ARowReal;
  logic [4*Width-1:0] ARowImag;
  logic [4*Width-1:0] BColReal;
  logic [4*Width-1:0] BColImag;
  logic               Busy;
  logic               Done;

  modport master (
    output LoadValid, LoadSel, LoadAddr,
    output LoadReal, LoadImag, Start, Hold,
    input  Enable, RowIdx, ColIdx,
    input  ARowReal, ARowImag,
    input  BColReal, BColImag, Busy, Done
  );

  modport slave (
    input  LoadValid, LoadSel, LoadAddr,
    input  LoadReal, LoadImag, Start, Hold,
    output Enable, RowIdx, ColIdx,
    output ARowReal, ARowImag,
    output BColReal, BColImag, Busy, Done
  );
endinterface

// File: rtl/row_col_sequencer.sv
// Stores two 4x4 complex matrices and issues (row i of A, column j of B)
// pairs in row-major order, one per non-held cycle.
module row_col_sequencer #(
  parameter int Width = 8
) (
  input logic               CLK,
  input logic               reset,
  row_col_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state = IDLE;
  logic [3:0]         n     = '0;
  logic               en    = 1'b0;
  logic               done  = 1'b0;
  logic [1:0]         row   = '0;
  logic [1:0]         col   = '0;
  logic [4*Width-1:0] ar    = '0;
  logic [4*Width-1:0] ai    = '0;
  logic [4*Width-1:0] br    = '0;
  logic [4*Width-1:0] bi    = '0;

  logic [Width-1:0] a_re [16];
  logic [Width-1:0] a_im [16];
  logic [Width-1:0] b_re [16];
  logic [Width-1:0] b_im [16];

  logic [4*Width-1:0] ar_nx;
  logic [4*Width-1:0] ai_nx;
  logic [4*Width-1:0] br_nx;
  logic [4*Width-1:0] bi_nx;

  // Row n[3:2] of A and column n[1:0] of B, element k in slot k.
  always_comb begin
    ar_nx = '0;
    ai_nx = '0;
    br_nx = '0;
    bi_nx = '0;
    for (int k = 0; k < 4; k++) begin
      ar_nx[k*Width +: Width] = a_re[{n[3:2], 2'(k)}];
      ai_nx[k*Width +: Width] = a_im[{n[3:2], 2'(k)}];
      br_nx[k*Width +: Width] = b_re[{2'(k), n[1:0]}];
      bi_nx[k*Width +: Width] = b_im[{2'(k), n[1:0]}];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      n     <= '0;
      en    <= 1'b0;
      done  <= 1'b0;
      row   <= '0;
      col   <= '0;
      ar    <= '0;
      ai    <= '0;
      br    <= '0;
      bi    <= '0;
      for (int e = 0; e < 16; e++) begin
        a_re[e] <= '0;
        a_im[e] <= '0;
        b_re[e] <= '0;
        b_im[e] <= '0;
      end
    end else begin
      en   <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.LoadValid) begin
            if (bus.LoadSel) begin
              b_re[bus.LoadAddr] <= bus.LoadReal;
              b_im[bus.LoadAddr] <= bus.LoadImag;
            end else begin
              a_re[bus.LoadAddr] <= bus.LoadReal;
              a_im[bus.LoadAddr] <= bus.LoadImag;
            end
          end
          if (bus.Start) begin
            state <= ISSUE;
            n     <= '0;
          end
        end
        ISSUE: begin
          if (!bus.Hold) begin
            en  <= 1'b1;
            row <= n[3:2];
            col <= n[1:0];
            ar  <= ar_nx;
            ai  <= ai_nx;
            br  <= br_nx;
            bi  <= bi_nx;
            n   <= n + 4'd1;
            if (n == 4'd15)
              state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Enable   = en;
  assign bus.Done     = done;
  assign bus.Busy     = (state != IDLE);
  assign bus.RowIdx   = row;
  assign bus.ColIdx   = col;
  assign bus.ARowReal = ar;
  assign bus.ARowImag = ai;
  assign bus.BColReal = br;
  assign bus.BColImag = bi;
endmodule

// File: doc/row_col_sequencer.md
ROW_COL_SEQUENCER -- requirements
Module: row_col_sequencer

Interface
REQ-001 The block SHALL have parameter Width, default 8, meaning the signed bit width of each real or imaginary matrix element part.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 LoadValid  input  1  element write strobe.
REQ-005 LoadSel  input  1  0 = write matrix A, 1 = write matrix B.
REQ-006 LoadAddr  input  4  element address, row*4+col.
REQ-007 LoadReal, LoadImag  input  Width each  signed element value.
REQ-008 Start  input  1  begin the issue sequence.
REQ-009 Hold  input  1  downstream back-pressure; freezes sequencing.
REQ-010 Enable  output  1  registered strobe; high means the output row/column is valid for capture this cycle.
REQ-011 RowIdx, ColIdx  output  2 each  (i,j) of the pair currently presented.
REQ-012 ARowReal, ARowImag  output  4*Width each  row i of A; element A(i,k) at bits [k*Width +: Width], k=0..3.
REQ-013 BColReal, BColImag  output  4*Width each  column j of B; element B(k,j) at bits [k*Width +: Width].
REQ-014 Busy  output  1  high when FSM not IDLE.
REQ-015 Done  output  1  one-cycle completion pulse.

Function
REQ-016 Storage SHALL be 2 x 16 complex entries (A, B), each entry Width real + Width imag.
REQ-017 A write SHALL occur at a rising edge only when LoadValid=1 and state=IDLE; writes in other states SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, ISSUE, DONE; Busy = (state != IDLE).
REQ-019 IDLE -> ISSUE on an edge with Start=1; pair counter n (4 bits) SHALL be cleared to 0; Start in ISSUE/DONE SHALL be ignored.
REQ-020 In ISSUE, each edge with Hold=0 SHALL load outputs with pair n (i=n[3:2], j=n[1:0]), set Enable=1, and increment n.
REQ-021 In ISSUE, an edge with Hold=1 SHALL set Enable=0 and leave n, RowIdx, ColIdx and data outputs unchanged.
REQ-022 The edge that loads pair 15 SHALL move the state to DONE; n SHALL wrap to 0.
REQ-023 In DONE, the next edge SHALL set Enable=0 and Done=1, and return the state to IDLE; Done SHALL be 0 on every other edge.
REQ-024 Order SHALL be row-major: (0,0),(0,1),(0,2),(0,3),(1,0)...(3,3); exactly 16 Enable cycles per run.
REQ-025 Latency: with Hold=0, Start at edge k gives Enable high after edges k+1..k+16, Done high after edge k+17, Busy low after k+17.
REQ-026 A write and Start on the same IDLE edge SHALL both take effect; the written value SHALL appear in the issued data.
REQ-027 Data outputs SHALL hold their last values when Enable=0 (outside reset); no arithmetic, pure selection.

Reset
REQ-028 With reset=1 at an edge, state SHALL go to IDLE, n=0, all storage entries = 0, Enable=0, Done=0, RowIdx=ColIdx=0, all data outputs = 0; reset SHALL take priority over Start, LoadValid and Hold.
REQ-029 Reset asserted mid-ISSUE SHALL abort the run with no Done pulse.
REQ-030 All registered outputs SHALL also power up at 0.

Verification
REQ-031 Load A(r,c)=r*4+c+1 real, -(r*4+c+1) imag, B identity; Start, Hold=0 -> 16 Enable cycles, pair (1,2) shows ARowReal elements 5,6,7,8 and BColReal 0,0,1,0; Done after edge k+17.
REQ-032 Hold=1 for 3 cycles after pair (0,1) -> Enable low 3 cycles, outputs frozen at (0,1), next Enable shows (0,2); Done delayed by 3 cycles.
REQ-033 LoadValid during ISSUE writing A(0,0)=0x7F -> ignored; next run shows original A(0,0).
REQ-034 Start while Busy -> no restart; exactly 16 Enable cycles and one Done pulse.
REQ-035 reset at 8th Enable cycle -> all outputs 0, Busy=0, no Done; subsequent Start issues all-zero data.
REQ-036 Same-edge LoadValid (B(3,3)=-128 real) and Start -> pair (3,3) shows BColReal element 3 = -128.
